// File: rtl/ccff_pkg.sv
// Shared types and default widths for the ccff bitstream loader.
package ccff_pkg;

  localparam int unsigned CCFF_WORD_W = 32;
  localparam int unsigned CCFF_LEN_W  = 16;
  localparam int unsigned CCFF_ERR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_ld_state_t;

endpackage

// File: rtl/ccff_piso_shreg.sv
// Parallel-in serial-out word register, MSB first.
// o_bit is the register MSB, so it drives ccff_head glitch-free.
module ccff_piso_shreg
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = CCFF_WORD_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;

  // Word storage and index of the bit currently presented on o_bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= {WORD_W{1'b0}};
      r_idx  <= {IDX_W{1'b0}};
    end else if (i_load) begin
      r_data <= i_data;
      r_idx  <= IDX_W'(WORD_W - 1);
    end else if (i_shift) begin
      r_data <= {r_data[WORD_W-2:0], 1'b0};
      r_idx  <= r_idx - IDX_W'(1);
    end else begin
      r_data <= r_data;
      r_idx  <= r_idx;
    end
  end

  assign o_bit  = r_data[WORD_W-1];
  assign o_last = (r_idx == {IDX_W{1'b0}});

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises a word stream onto the ccff chain head and optionally
// compares the chain tail against a re-sent bitstream.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = CCFF_WORD_W,
  parameter int unsigned LEN_W  = CCFF_LEN_W,
  parameter int unsigned ERR_W  = CCFF_ERR_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_verify,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  ccff_ld_state_t r_state, w_next_state;

  logic [LEN_W-1:0] r_len, r_cnt, w_cnt_nxt;
  logic             r_verify;
  logic             r_s_ready, r_shift_en, r_busy, r_done, r_mismatch;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_load, w_shift, w_shift_en_nxt;
  logic             w_bit, w_last, w_start, w_hs, w_len_done;

  assign w_start    = cfg_start && (r_state == ST_IDLE);
  assign w_hs       = s_valid && r_s_ready;
  assign w_len_done = (r_cnt == r_len);

  ccff_piso_shreg #(.WORD_W(WORD_W)) u_shreg (
    .i_clk   (prog_clk),
    .i_rst   (pReset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (s_data),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

  // FSM state register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic; the length limit wins over the word boundary.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_next_state = (cfg_len != {LEN_W{1'b0}}) ? ST_FETCH : ST_DONE;
        else           w_next_state = ST_IDLE;
      end
      ST_FETCH: begin
        if (w_hs) w_next_state = ST_SHIFT;
        else      w_next_state = ST_FETCH;
      end
      ST_SHIFT: begin
        if (w_len_done)  w_next_state = ST_DONE;
        else if (w_last) w_next_state = ST_FETCH;
        else             w_next_state = ST_SHIFT;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM output logic: shift-register control, next shift enable and bit count.
  always_comb begin
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_shift_en_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_cnt_nxt = {LEN_W{1'b0}};
        else           w_cnt_nxt = r_cnt;
      end
      ST_FETCH: begin
        if (w_hs) begin
          w_load         = 1'b1;
          w_shift_en_nxt = 1'b1;
          w_cnt_nxt      = r_cnt + LEN_W'(1);
        end else begin
          w_load         = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!w_len_done && !w_last) begin
          w_shift        = 1'b1;
          w_shift_en_nxt = 1'b1;
          w_cnt_nxt      = r_cnt + LEN_W'(1);
        end else begin
          w_shift        = 1'b0;
        end
      end
      ST_DONE: w_cnt_nxt = r_cnt;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Registered handshake/status outputs and the latched pass configuration.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_s_ready  <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= {LEN_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
      r_verify   <= 1'b0;
    end else begin
      r_s_ready  <= (w_next_state == ST_FETCH);
      r_shift_en <= w_shift_en_nxt;
      r_busy     <= (w_next_state == ST_FETCH) || (w_next_state == ST_SHIFT);
      r_done     <= (w_next_state == ST_DONE);
      r_cnt      <= w_cnt_nxt;
      if (w_start) begin
        r_len    <= cfg_len;
        r_verify <= cfg_verify;
      end else begin
        r_len    <= r_len;
        r_verify <= r_verify;
      end
    end
  end

  // Verify compare: on a shift edge the tail carries the load-pass bit for this position.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= {ERR_W{1'b0}};
    end else if (w_start) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= {ERR_W{1'b0}};
    end else if (r_verify && r_shift_en && (ccff_tail != w_bit)) begin
      r_mismatch <= 1'b1;
      r_err_cnt  <= sat_inc(r_err_cnt);
    end else begin
      r_mismatch <= r_mismatch;
      r_err_cnt  <= r_err_cnt;
    end
  end

  assign s_ready   = r_s_ready;
  assign ccff_head = w_bit;
  assign shift_en  = r_shift_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mismatch  = r_mismatch;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: driver queues expected head bits and pass results,
// a negedge monitor compares; a behavioural chain model drives ccff_tail.
module tb_ccff_bitstream_loader;

  typedef struct {
    int len;
    int busy;
    int first;
    int err;
    bit mm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_verify = 1'b0;
  logic [15:0] cfg_len = 16'd0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready, ccff_head, shift_en, ccff_tail, busy, done, mismatch;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit   q_bits[$];
  exp_t q_exp[$];
  int   passes_seen = 0;

  logic [31:0] g_words[0:7];
  logic [31:0] g_save[0:7];
  int          g_stall[0:7];
  bit          last_bits[0:255];
  bit          snap[0:255];
  bit          chain[0:255];
  int          chain_len = 1;

  ccff_bitstream_loader dut (
    .prog_clk   (clk),
    .pReset     (rst),
    .cfg_start  (cfg_start),
    .cfg_verify (cfg_verify),
    .cfg_len    (cfg_len),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .ccff_head  (ccff_head),
    .shift_en   (shift_en),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Configuration chain: a plain shift register of chain_len stages.
  always @(posedge clk) begin
    if (shift_en === 1'b1) begin
      for (int i = 255; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= ccff_head;
    end
  end
  assign ccff_tail = chain[chain_len-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  int   m_shifts = 0;
  int   m_busy = 0;
  int   m_first = -1;
  bit   m_done_next = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst) begin
      q_bits.delete();
      q_exp.delete();
      m_shifts = 0;
      m_busy = 0;
      m_first = -1;
      m_done_next = 1'b0;
    end else begin
      if (m_done_next) begin
        chk("done_one_cycle", done, 0);
        m_done_next = 1'b0;
      end
      if (shift_en) begin
        if (m_first < 0) m_first = m_busy;
        m_shifts++;
        if (q_bits.size() == 0) chk("bit_queue_underflow", 1, 0);
        else                    chk("head_bit", ccff_head, q_bits.pop_front());
      end
      if (busy) m_busy++;
      if (done) begin
        if (q_exp.size() == 0) chk("exp_queue_underflow", 1, 0);
        else begin
          m_e = q_exp.pop_front();
          chk("shift_count", m_shifts, m_e.len);
          chk("busy_cycles", m_busy, m_e.busy);
          if (m_e.len > 0) chk("first_shift_latency", m_first, m_e.first);
          chk("busy_low_at_done", busy, 0);
          chk("mismatch", mismatch, m_e.mm);
          chk("err_cnt", err_cnt, m_e.err);
          chk("bits_left", q_bits.size(), 0);
        end
        passes_seen++;
        m_shifts = 0;
        m_busy = 0;
        m_first = -1;
        m_done_next = 1'b1;
      end
    end
  end

  task automatic feed_word(input logic [31:0] w, input int stall, input int abort,
                           inout int sh, output bit ab);
    int t;
    ab = 1'b0;
    t = 0;
    while (!s_ready && t < 400) begin
      if (shift_en) sh++;
      if (abort > 0 && sh >= abort) begin
        ab = 1'b1;
        return;
      end
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      chk("ready_timeout", 0, 1);
      ab = 1'b1;
      return;
    end
    repeat (stall) @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_pass(input int len, input bit verify, input int abort, input bit inj);
    bit          b[0:255];
    int          nwords, ssum, err, sh, target, t, nbad;
    bit          ab;
    exp_t        e;
    logic [31:0] w;
    nwords = (len + 31) / 32;
    ssum = 0;
    for (int i = 0; i < nwords; i++) ssum += g_stall[i];
    for (int k = 0; k < len; k++) begin
      w = g_words[k/32];
      b[k] = w[31 - (k % 32)];
    end
    err = 0;
    if (verify) for (int k = 0; k < len; k++) if (b[k] != last_bits[k]) err++;
    if (err > 65535) err = 65535;
    e.len = len;
    e.busy = (len == 0) ? 0 : nwords + len + ssum;
    e.first = 1 + g_stall[0];
    e.err = err;
    e.mm = (err != 0);
    for (int k = 0; k < len; k++) q_bits.push_back(b[k]);
    q_exp.push_back(e);
    if (!verify && len > 0) chain_len = len;
    target = passes_seen + 1;

    @(negedge clk);
    cfg_start  = 1'b1;
    cfg_len    = 16'(len);
    cfg_verify = verify;
    @(negedge clk);
    cfg_start  = 1'b0;
    cfg_len    = 16'($urandom);
    cfg_verify = 1'($urandom);
    sh = 0;
    ab = 1'b0;
    for (int i = 0; i < nwords && !ab; i++) begin
      feed_word(g_words[i], g_stall[i], abort, sh, ab);
      if (!ab) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
        if (i == 0 && inj) begin
          cfg_start = 1'b1;
          cfg_len   = 16'd3;
          @(negedge clk);
          cfg_start = 1'b0;
        end
      end
    end

    if (ab) begin
      chk("busy_before_reset", busy, 1);
      chk("err_before_reset_nonzero", (err_cnt != 16'd0), 1);
      #2 rst = 1'b1;
      #1 chk("reset_async", {s_ready, ccff_head, shift_en, busy, done, mismatch, err_cnt}, 0);
      s_valid   = 1'b0;
      cfg_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    t = 0;
    while (passes_seen < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("pass_done_seen", (passes_seen >= target), 1);
    if (len > 0) for (int k = 0; k < len; k++) last_bits[k] = b[k];
    if (!verify && len > 0) begin
      nbad = 0;
      for (int k = 0; k < len; k++) if (chain[len-1-k] != b[k]) nbad++;
      chk("chain_content", nbad, 0);
    end
  endtask

  task automatic save_words();
    for (int i = 0; i < 8; i++) g_save[i] = g_words[i];
  endtask

  task automatic restore_words();
    for (int i = 0; i < 8; i++) g_words[i] = g_save[i];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad, len;
    for (int i = 0; i < 8; i++) begin
      g_words[i] = 32'd0;
      g_stall[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_state", {s_ready, ccff_head, shift_en, busy, done, mismatch, err_cnt}, 0);

    g_words[0] = 32'hDEADBEEF;
    g_words[1] = 32'h12345600;
    save_words();
    run_pass(56, 1'b0, 0, 1'b1);
    for (int i = 0; i < 256; i++) snap[i] = chain[i];

    run_pass(56, 1'b1, 0, 1'b0);

    g_words[0] = g_words[0] ^ 32'h0000_0020;
    run_pass(56, 1'b1, 0, 1'b0);
    restore_words();

    run_pass(56, 1'b0, 0, 1'b0);
    g_words[0] = ~g_save[0];
    g_words[1] = ~g_save[1];
    run_pass(56, 1'b1, 0, 1'b0);
    restore_words();

    g_stall[1] = 10;
    run_pass(56, 1'b0, 0, 1'b0);
    g_stall[1] = 0;
    nbad = 0;
    for (int i = 0; i < 56; i++) if (chain[i] != snap[i]) nbad++;
    chk("stall_chain_vs_nostall", nbad, 0);

    run_pass(0, 1'b0, 0, 1'b0);

    g_words[0] = ~g_save[0];
    g_words[1] = ~g_save[1];
    run_pass(56, 1'b1, 20, 1'b0);
    restore_words();
    run_pass(56, 1'b0, 0, 1'b0);
    run_pass(56, 1'b1, 0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 200);
      for (int i = 0; i < 8; i++) begin
        g_words[i] = $urandom;
        g_stall[i] = $urandom_range(0, 3);
      end
      run_pass(len, 1'b0, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) g_words[i] = g_words[i] ^ (32'h1 << $urandom_range(0, 31));
        g_stall[i] = $urandom_range(0, 2);
      end
      run_pass(len, 1'b1, 0, 1'b0);
    end
    for (int i = 0; i < 8; i++) g_stall[i] = 0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
